// File: rtl/cereal_pkg.sv
// Shared types and constants for the cereal serial transmitter.
package cereal_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam logic LINE_IDLE            = 1'b1;
   localparam int   DATA_BITS            = 8;
   localparam int   DEFAULT_CLKS_PER_BIT = 5208;   // 50 MHz / 9600 baud

endpackage

// File: rtl/cereal_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last
// count, wrapping to zero. Held at zero while clear is high.
module cereal_baud
   import cereal_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic sysclk,
   input  logic rst,
   input  logic clear,
   output logic bit_done
);

   localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

   logic [15:0] count_reg;

   assign bit_done = (count_reg == LAST_COUNT) && !clear;

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clear || bit_done) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 16'd1;
      end
   end

endmodule

// File: rtl/cereal_tx.sv
// Asynchronous serial frame transmitter: start, 8 data bits LSB first, optional
// even parity (define CEREAL_PARITY_EN), STOP_BITS stop bits.
module cereal_tx
   import cereal_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       start,
   output logic       cereal,
   output logic       busy
);

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

   state_t     state_reg, state_next;
   logic [7:0] shift_reg, shift_next;
   logic [2:0] bit_idx_reg, bit_idx_next;
   logic       stop_idx_reg, stop_idx_next;
   logic       busy_reg, busy_next;
   logic       cereal_reg, cereal_next;
   logic       start_q_reg;
   logic       armed_reg;
   logic       accept;
   logic       bit_done;
`ifdef CEREAL_PARITY_EN
   logic       parity_reg, parity_next;
`endif

   // armed_reg blocks a start that is already high when reset releases from
   // counting as an edge; it needs one low cycle first.
   assign accept = start && !start_q_reg && armed_reg && (state_reg == ST_IDLE);

   cereal_baud #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .sysclk  (sysclk),
      .rst     (rst),
      .clear   (state_reg == ST_IDLE),
      .bit_done(bit_done)
   );

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         shift_reg    <= '0;
         bit_idx_reg  <= '0;
         stop_idx_reg <= 1'b0;
         busy_reg     <= 1'b0;
         cereal_reg   <= LINE_IDLE;
         start_q_reg  <= 1'b0;
         armed_reg    <= 1'b0;
`ifdef CEREAL_PARITY_EN
         parity_reg   <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         bit_idx_reg  <= bit_idx_next;
         stop_idx_reg <= stop_idx_next;
         busy_reg     <= busy_next;
         cereal_reg   <= cereal_next;
         start_q_reg  <= start;
         armed_reg    <= armed_reg || !start;
`ifdef CEREAL_PARITY_EN
         parity_reg   <= parity_next;
`endif
      end
   end

   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      bit_idx_next  = bit_idx_reg;
      stop_idx_next = stop_idx_reg;
      busy_next     = busy_reg;
      cereal_next   = LINE_IDLE;
`ifdef CEREAL_PARITY_EN
      parity_next   = parity_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               shift_next    = data;
               bit_idx_next  = '0;
               stop_idx_next = 1'b0;
               busy_next     = 1'b1;
               state_next    = ST_START;
`ifdef CEREAL_PARITY_EN
               parity_next   = ^data;
`endif
            end
         end
         ST_START: begin
            if (bit_done) state_next = ST_DATA;
         end
         ST_DATA: begin
            if (bit_done) begin
               shift_next = {1'b0, shift_reg[7:1]};
               if (bit_idx_reg == LAST_BIT) begin
`ifdef CEREAL_PARITY_EN
                  state_next = ST_PARITY;
`else
                  state_next = ST_STOP;
`endif
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
               end
            end
         end
`ifdef CEREAL_PARITY_EN
         ST_PARITY: begin
            if (bit_done) state_next = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_done) begin
               if (stop_idx_reg == STOP_LAST) begin
                  state_next = ST_IDLE;
                  busy_next  = 1'b0;
               end else begin
                  stop_idx_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
         end
      endcase

      // Line level is registered from the state being entered so it lines up
      // with the state register, keeping inputs off the output path.
      case (state_next)
         ST_START:  cereal_next = 1'b0;
         ST_DATA:   cereal_next = shift_next[0];
`ifdef CEREAL_PARITY_EN
         ST_PARITY: cereal_next = parity_next;
`endif
         default:   cereal_next = LINE_IDLE;
      endcase
   end

   assign cereal = cereal_reg;
   assign busy   = busy_reg;

endmodule

// File: doc/cereal_tx.md
Name: cereal_tx

Overview:
Serial transmitter stage directly downstream of the switch/button keyboard front end. Takes the 8-bit ASCII code and start strobe the keyboard produces, and shifts one asynchronous serial frame out on a single line: start bit, 8 data bits LSB first, optional parity, stop bit(s). Drives the board's serial output pin and reports a busy flag.

Parameters:
CLKS_PER_BIT, 5208, sysclk cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
sysclk  input  1  system clock; all state on its rising edge.
rst  input  1  asynchronous, active-high reset.
data  input  8  byte to send; sampled only on the accept cycle.
start  input  1  send request; level signal, may stay high for many cycles (held while the button is pressed).
cereal  output  1  serial line, idle high, registered.
busy  output  1  high while a frame is in progress, registered.

Behaviour:
- Reset values: cereal=1, busy=0, FSM=IDLE, baud counter=0, bit index=0, start_q=0, shift register=0.
- Edge detect: start_q <= start every cycle. accept = start & ~start_q & (state==IDLE).
- One frame per rising edge of start. Holding start high never retransmits; a new frame needs start low then high again.
- A rising edge of start while busy is dropped, not queued. If start is still high when the frame ends, nothing is sent.
- On the accept cycle: latch data into the shift register, enter START, busy<=1. cereal goes low on the next edge (latency 1 cycle).
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Every state except IDLE lasts exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and clears on each state or bit change.
- START: cereal=0.
- DATA: cereal = shift[0]. Shift right at the end of each bit. 8 bits, index 0..7; leave after index 7.
- STOP: cereal=1 for STOP_BITS*CLKS_PER_BIT cycles.
- At the end of STOP: busy<=0, state IDLE. An accept is possible on the very next cycle.
- Frame length (no parity, STOP_BITS=1): 10*CLKS_PER_BIT cycles from the first low cycle to busy falling.
- Data changes after the accept cycle do not affect the frame in flight.
- Reset asserted mid-frame: cereal returns high and busy drops immediately (asynchronously). No partial-frame completion after release. A start already high at reset release is not treated as an edge until it goes low and high again.
- No combinational path from inputs to outputs.

Optional Feature:
CEREAL_PARITY_EN
- Defined: after DATA, a PARITY state lasting CLKS_PER_BIT cycles drives the even-parity bit (XOR of the 8 latched data bits). Frame = 11*CLKS_PER_BIT cycles with STOP_BITS=1.
- Undefined: no PARITY state and no parity logic; DATA goes straight to STOP.

Decomposition:
- Package cereal_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - LINE_IDLE=1'b1, DATA_BITS=8.
  - Default CLKS_PER_BIT constant.
- One natural sub-module, cereal_baud: parameterised counter taking a clear input and emitting a one-cycle bit_done pulse when the count reaches CLKS_PER_BIT-1.
- FSM and shift register stay in cereal_tx.

Test Plan:
- CLKS_PER_BIT=4, STOP_BITS=1, data=0x35, one-cycle start pulse -> cereal low 4 cycles, then 1,0,1,0,1,1,0,0 (4 cycles each), then high 4 cycles. busy high exactly 40 cycles.
- start held high 200 cycles, data=0x39 -> exactly one frame. start low then high again -> second frame of 0x39.
- Second start edge 10 cycles into a 0x30 frame, data changed to 0x55 -> that edge is ignored. Line shows only 0x30 bits.
- Reset asserted during data bit 3 -> cereal=1 and busy=0 in the same cycle. After release with start low, the line stays high.
- STOP_BITS=2, data=0x55 -> stop phase is 8 cycles high. A new start edge on the cycle after busy falls is accepted.
- CEREAL_PARITY_EN defined, data=0x31 -> parity bit 1 after bit 7. data=0x35 -> parity bit 0. Frame is 44 cycles.
